// File: rtl/inst_mem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder and its loader.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

package inst_mem_resp_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/ld_word_pack.sv
// Packs the boot loader's byte stream into little-endian 32-bit words,
// zero-padding the upper lanes when the final byte closes a partial word.
module ld_word_pack
  import inst_mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_last_i,
  output logic              word_valid_o,
  output logic [INST_W-1:0] word_data_o
);

  lane_t             lane_q, lane_d;
  logic [INST_W-1:0] asm_q, asm_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    lane_d       = lane_q;
    asm_d        = asm_q;
    // Lanes above lane_q are always zero in asm_q, which gives the zero-pad for free.
    word_data_o  = asm_q | (INST_W'(byte_i) << {lane_q, 3'b000});
    word_valid_o = byte_valid_i && ((lane_q == 2'd3) || byte_last_i);
    if (byte_valid_i) begin
      if (word_valid_o) begin
        lane_d = '0;
        asm_d  = '0;
      end else begin
        lane_d = lane_q + lane_t'(1);
        asm_d  = word_data_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: boot-time byte loader (LOAD) followed by
// single-cycle fetch service with stall/flush handling (RUN).
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int                DEPTH    = 1024,
  parameter int                ADDR_W   = `MEM_ADDR_WIDTH,
  parameter logic [INST_W-1:0] NOP_INST = inst_mem_resp_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  input  logic              flush,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              fetch_err,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_ready
);

  localparam int IDX_W = $clog2(DEPTH);

  // One extra bit so the index can reach DEPTH.
  typedef logic [IDX_W:0] widx_t;

  state_e            state_q, state_d;
  widx_t             widx_q, widx_d;
  logic              mem_ready_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic              err_q;
  logic [INST_W-1:0] mem [DEPTH];

  logic              ld_accept;
  logic              word_valid;
  logic [INST_W-1:0] word_data;
  logic [63:0]       addr_ext;
  logic              addr_bad;
  logic [IDX_W-1:0]  rd_idx;

  assign ld_accept = ld_valid && ld_ready;

  ld_word_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (ld_accept),
    .byte_i       (ld_byte),
    .byte_last_i  (ld_last),
    .word_valid_o (word_valid),
    .word_data_o  (word_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    if (state_q == LOAD) begin
      if (word_valid) widx_d = widx_q + widx_t'(1);
      if ((ld_accept && ld_last) ||
          (word_valid && (widx_q == widx_t'(DEPTH - 1))))
        state_d = RUN;
    end
  end

  always_comb begin
    ld_ready = (state_q == LOAD);
  end

  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the loader fills it before fetch opens, and a resettable array cannot map onto RAM.
    if (!rst && word_valid) mem[widx_q[IDX_W-1:0]] <= word_data;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_ready_q <= 1'b0;
    else     mem_ready_q <= (state_q == RUN);
  end

  // Upper address bits are range-checked rather than dropped by the index slice.
  assign addr_ext = 64'(addr);
  assign addr_bad = (addr[1:0] != 2'b00) || (addr_ext >= (64'(DEPTH) << 2));
  assign rd_idx   = addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst || !mem_ready_q || flush) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (stall) begin
      err_q <= 1'b0;
    end else if (rd_en) begin
      if (addr_bad) begin
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        inst_q  <= mem[rd_idx];
        valid_q <= 1'b1;
        err_q   <= 1'b0;
      end
    end else begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  assign inst_out   = inst_q;
  assign inst_valid = valid_q;
  assign fetch_err  = err_q;
  assign mem_ready  = mem_ready_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp: a behavioural model predicts each cycle's
// output, and a negedge monitor pops and compares it against the DUT.
module tb_inst_mem_resp;
  import inst_mem_resp_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int BYTES  = 4 * DEPTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic              stall;
  logic              flush;
  logic [31:0]       inst_out;
  logic              inst_valid;
  logic              fetch_err;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              ld_ready;
  logic              mem_ready;

  always #5 clk = ~clk;

  inst_mem_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .addr       (addr),
    .stall      (stall),
    .flush      (flush),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .fetch_err  (fetch_err),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .mem_ready  (mem_ready)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        prev;
  logic [31:0] mem_model [DEPTH];
  bit          known [DEPTH];
  bit          fetch_en;
  logic [7:0]  ld_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("inst_out",   inst_out,          e.inst);
      check("inst_valid", 32'(inst_valid),   32'(e.valid));
      check("fetch_err",  32'(fetch_err),    32'(e.err));
    end
  end

  // Drive one cycle from a negedge, predict the registered result and queue it.
  task automatic drive_cycle(input bit r, input bit s, input bit f, input logic [31:0] a);
    exp_t e;
    rd_en = r; stall = s; flush = f; addr = a;
    if (rst || !fetch_en || f)         e = '{NOP_INST, 1'b0, 1'b0};
    else if (s)                        e = '{prev.inst, prev.valid, 1'b0};
    else if (r && (a % 4 != 0 || a >= BYTES)) e = '{NOP_INST, 1'b0, 1'b1};
    else if (r)                        e = '{mem_model[a / 4], 1'b1, 1'b0};
    else                               e = '{NOP_INST, 1'b0, 1'b0};
    prev = e;
    @(posedge clk);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    check("rst_ld_ready",  32'(ld_ready),  32'd1);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    rst = 1'b0;
  endtask

  // Streams ld_q; a byte is expected to be taken while fewer than 4*DEPTH have been taken.
  task automatic load_bytes(input bit with_last);
    logic [31:0] wbuf;
    int          acc;
    int          lane;
    wbuf = '0;
    acc  = 0;
    for (int i = 0; i < ld_q.size(); i++) begin
      bit take;
      bit last;
      last     = with_last && (i == ld_q.size() - 1);
      take     = (acc < BYTES);
      ld_valid = 1'b1; ld_byte = ld_q[i]; ld_last = last;
      check("ld_ready", 32'(ld_ready), 32'(take));
      if (take) begin
        lane = acc % 4;
        if (lane == 0) wbuf = '0;
        wbuf = wbuf | (32'(ld_q[i]) << (8 * lane));
        if (lane == 3 || last) begin
          mem_model[acc / 4] = wbuf;
          known[acc / 4]     = 1'b1;
        end
        acc++;
      end
      drive_cycle(take ? 1'($urandom_range(0, 1)) : 1'b0, 0, 0, $urandom);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_ready();
    check("mem_ready_early", 32'(mem_ready), 32'd0);
    drive_cycle(0, 0, 0, 0);
    check("mem_ready",    32'(mem_ready), 32'd1);
    check("ld_ready_run", 32'(ld_ready),  32'd0);
    fetch_en = 1'b1;
  endtask

  task automatic rand_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      bit          r, s, f;
      int          k, idx;
      logic [31:0] a;
      r   = ($urandom_range(0, 9) < 7);
      s   = ($urandom_range(0, 9) < 2);
      f   = ($urandom_range(0, 9) == 0);
      k   = $urandom_range(0, 19);
      idx = $urandom_range(0, DEPTH - 1);
      if (k < 14)       a = 32'(idx * 4);
      else if (k < 17)  a = 32'(idx * 4 + $urandom_range(1, 3));
      else if (k == 17) a = 32'(BYTES);
      else              a = 32'h8000_0000 | 32'(idx * 4);
      if (!known[idx]) r = 1'b0;
      drive_cycle(r, s, f, a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_en = 1'b0; addr = '0; stall = 1'b0; flush = 1'b0;
    ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0; fetch_en = 1'b0;
    prev = '{NOP_INST, 1'b0, 1'b0};
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    @(negedge clk);

    do_reset();
    check("rst_inst_out",   inst_out,          NOP_INST);
    check("rst_inst_valid", 32'(inst_valid),   32'd0);
    check("rst_fetch_err",  32'(fetch_err),    32'd0);

    // Two full little-endian words.
    ld_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
    load_bytes(1);
    wait_ready();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 4);
    drive_cycle(0, 0, 0, 0);

    // Partial final word is zero-padded.
    do_reset();
    ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_bytes(1);
    wait_ready();
    drive_cycle(1, 0, 0, 4);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);

    // Back-to-back fetch, stall, bad addresses, flush.
    do_reset();
    ld_q.delete();
    for (int i = 0; i < 12; i++) ld_q.push_back(8'($urandom));
    load_bytes(1);
    wait_ready();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 4);
    drive_cycle(1, 1, 0, 8);
    drive_cycle(1, 1, 0, 8);
    drive_cycle(1, 0, 0, 8);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 0, 0, 6);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 0, 0, 32'(BYTES));
    drive_cycle(0, 1, 0, 0);
    drive_cycle(1, 0, 0, 4);
    drive_cycle(1, 1, 1, 8);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0);

    // Overflow: 4*DEPTH+3 bytes, only 4*DEPTH accepted, then automatic RUN.
    do_reset();
    ld_q.delete();
    for (int i = 0; i < BYTES + 3; i++) ld_q.push_back(8'($urandom));
    load_bytes(1);
    check("ovf_mem_ready", 32'(mem_ready), 32'd1);
    check("ovf_ld_ready",  32'(ld_ready),  32'd0);
    fetch_en = 1'b1;
    rand_fetch(300);

    // Reset mid-load discards the partial word and restarts at word 0.
    do_reset();
    ld_q = '{8'h01, 8'h02};
    load_bytes(0);
    do_reset();
    ld_q = '{8'h44, 8'h33, 8'h22, 8'h11};
    load_bytes(1);
    wait_ready();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);

    // Random loads of random length followed by random fetch traffic.
    for (int t = 0; t < 3; t++) begin
      int n;
      do_reset();
      n = $urandom_range(1, BYTES);
      ld_q.delete();
      for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
      load_bytes(1);
      wait_ready();
      rand_fetch(150);
    end

    begin
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("sb_drain", 32'(sb_q.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Instruction-memory responder serving the IF-stage fetch requester: it accepts a byte-aligned PC address with a read enable and returns the 32-bit instruction one cycle later.
- It also owns a boot-time byte-serial program loader that packs bytes little-endian into words before fetch is allowed.
- It honours pipeline stall (hold) and branch flush (bubble) so the IF/ID boundary sees a consistent instruction stream.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; power of two, at least 4.
- ADDR_W, `MEM_ADDR_WIDTH, width of the fetch address (byte address).
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  1  fetch request from the PC unit.
- addr  in  ADDR_W  byte address of the fetch.
- stall  in  1  hold current output; the request is not consumed.
- flush  in  1  branch taken; discard the in-flight fetch.
- inst_out  out  32  fetched instruction.
- inst_valid  out  1  inst_out is a real instruction.
- fetch_err  out  1  one-cycle pulse on a misaligned or out-of-range fetch.
- ld_valid  in  1  loader byte strobe.
- ld_byte  in  8  loader data.
- ld_last  in  1  marks the final byte; qualified by ld_valid.
- ld_ready  out  1  loader byte accepted this cycle when ld_valid is high.
- mem_ready  out  1  load complete; fetch enabled.

Behaviour:
- State machine states: LOAD and RUN. Reset enters LOAD.
- Reset values:
  - inst_out = NOP_INST; inst_valid = 0; fetch_err = 0; mem_ready = 0; ld_ready = 1.
  - Byte lane counter = 0; write word index = 0; assembly register = 0.
  - Memory array is not cleared.
- LOAD:
  - A byte is accepted when ld_valid and ld_ready are both high. It goes into assembly lane lane_cnt, so byte0 = bits 7:0 (little-endian), and lane_cnt increments mod 4.
  - When lane 3 is accepted, the completed word is written to mem[widx] in the same cycle the last byte arrives, widx increments, and the assembly register clears.
  - When ld_last is accepted on lane k<3, lanes k+1..3 are zero-padded and the word is written.
  - When ld_last is accepted, the next state is RUN and mem_ready rises on the following cycle.
  - When widx reaches DEPTH, ld_ready drops to 0 and the FSM moves to RUN automatically (overflow: excess bytes are refused).
  - In LOAD, rd_en is ignored, inst_valid stays 0 and inst_out stays NOP_INST.
- RUN:
  - ld_ready = 0. RUN is left only via rst.
  - Fetch latency is 1 cycle: a request at edge N (rd_en=1, stall=0, flush=0) presents its result after edge N+1.
  - Normal fetch: inst_out <= mem[addr[log2(DEPTH)+1:2]], inst_valid <= 1.
  - Misaligned (addr[1:0] != 0) or out-of-range (addr >= 4*DEPTH): inst_out <= NOP_INST, inst_valid <= 0, fetch_err <= 1 for one cycle.
  - Priority, highest first:
    - flush: inst_out <= NOP_INST, inst_valid <= 0, no error. Flush beats stall.
    - stall: inst_out, inst_valid and fetch_err hold, except that fetch_err clears after 1 cycle.
    - rd_en: fetch as above.
    - Otherwise (rd_en=0): inst_valid <= 0, inst_out <= NOP_INST.
- Simultaneous events:
  - rst overrides everything.
  - rst mid-load discards the partial word; widx returns to 0, and words already written remain in memory but will be overwritten by the next load.
- Width rules: widx is log2(DEPTH)+1 bits so the DEPTH condition is representable; address upper bits beyond the index are checked for range, not truncated.

Decomposition:
- Shared package holds:
  - NOP_INST constant.
  - Responder state enum {LOAD, RUN}.
  - INST_W = 32.
  - Byte-lane type, 2 bits.
- One sub-module, ld_word_pack, is natural: the byte lane counter, assembly register, zero-pad on last, and a word_valid/word_data output.
- The top module keeps the FSM, memory array and fetch path.

Test Plan:
- Load bytes 13,00,00,00,B3,00,10,00 with ld_last on the 8th byte -> mem[0]=32'h00000013, mem[1]=32'h001000B3; mem_ready=1 two cycles after the last byte.
- Load 5 bytes AA,BB,CC,DD,EE with last on EE -> mem[1]=32'h000000EE; rd_en with addr=4 -> inst_out=32'h000000EE, inst_valid=1 one cycle later.
- Back-to-back fetch addr 0,4,8 -> outputs mem[0],mem[1],mem[2] on consecutive cycles, each lagging its request by 1 cycle; stall held 2 cycles mid-stream -> inst_out frozen, and the same addr is re-presented and served after the stall.
- Fetch addr=6 -> inst_out=NOP_INST, inst_valid=0, fetch_err pulses for 1 cycle; fetch addr=4*DEPTH -> same.
- flush and stall together with rd_en=1 -> next cycle inst_out=NOP_INST, inst_valid=0.
- Stream DEPTH*4+3 bytes -> ld_ready drops after byte 4*DEPTH, FSM enters RUN, extra bytes refused; rst after 2 bytes of a new load -> widx=0, mem_ready=0, ld_ready=1.
